// File: rtl/ppu_sprite_pkg.sv
// rtl/ppu_sprite_pkg.sv - shared sprite word layout, attribute bits and evaluator FSM encodings
//
// Purpose: common definitions for the sprite evaluator and its compare stage.
// Contents:
//   *_LSB        bit offsets of the four byte fields in a 32-bit sprite RAM word
//   ATTR_*       bit indices inside the attribute byte
//   ST_*         evaluator FSM state encodings
//   spr_field    extracts one byte field from a sprite word

package ppu_sprite_pkg;

  // Sprite RAM word: [31:24] y, [23:16] x, [15:8] tile, [7:0] attr
  localparam int Y_LSB    = 24;
  localparam int X_LSB    = 16;
  localparam int TILE_LSB = 8;
  localparam int ATTR_LSB = 0;

  // Attribute byte bit positions
  localparam int ATTR_VFLIP   = 7;
  localparam int ATTR_HFLIP   = 6;
  localparam int ATTR_PRIO    = 5;
  localparam int ATTR_DISABLE = 4;

  // Evaluator FSM
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [7:0] spr_field(input logic [31:0] word, input int lsb);
    return word[lsb +: 8];
  endfunction

endpackage

// File: rtl/sprite_hit_cmp.sv
// rtl/sprite_hit_cmp.sv - combinational sprite/scanline hit test and in-sprite row
//
// Purpose: decides whether a sprite covers a scanline and which of its rows lands there.
// Ports:
//   y         in   8        sprite top line
//   line_num  in   LINE_W   scanline being evaluated (LINE_W >= 8)
//   attr      in   8        sprite attribute byte (vflip, disable used here)
//   hit       out  1        sprite is enabled and covers line_num
//   row       out  7        row inside the sprite, vertically flipped when requested

module sprite_hit_cmp
  import ppu_sprite_pkg::*;
#(
  parameter int LINE_W = 8,
  parameter int SPR_H  = 16
) (
  input  logic [7:0]        y,
  input  logic [LINE_W-1:0] line_num,
  input  logic [7:0]        attr,
  output logic              hit,
  output logic [6:0]        row
);

  localparam int              DW     = LINE_W + 1;
  localparam logic [DW-1:0]   H_WIDE = DW'(SPR_H);
  localparam logic [6:0]      H_M1   = 7'(SPR_H - 1);

  logic [DW-1:0] y_ext;
  logic [DW-1:0] diff;
  logic          unused_attr;

  assign y_ext = {{(DW-8){1'b0}}, y};

  // One extra bit so a sprite below the line yields a negative (MSB set) diff;
  // no wrap-around: a sprite that starts near the bottom never reappears at the top.
  assign diff = {1'b0, line_num} - y_ext;

  assign hit = !diff[DW-1] && (diff < H_WIDE) && !attr[ATTR_DISABLE];

  // diff < SPR_H <= 128 whenever the row is consumed, so 7 bits hold it exactly.
  assign row = attr[ATTR_VFLIP] ? (H_M1 - diff[6:0]) : diff[6:0];

  assign unused_attr = ^{attr[6:5], attr[3:0]};

endmodule

// File: rtl/sprite_line_eval.sv
// rtl/sprite_line_eval.sv - per-scanline sprite evaluator feeding the sprite fetcher line buffer
//
// Purpose: on line_start, streams every sprite RAM entry through a 1-address-per-cycle
// pipeline and writes up to MAX_SPR covering sprites (with their in-sprite row) to the
// line buffer in scan order.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   line_start   1-cycle pulse, start (or restart) evaluation of line_num
//   line_num     scanline, sampled with line_start
//   ram_rdaddr   sprite RAM read address (synchronous BRAM, data one cycle later)
//   ram_rdata    sprite RAM read data
//   out_we       line-buffer write strobe
//   out_idx      line-buffer slot
//   out_data     {x, tile, attr, 1'b0, row[6:0]}
//   busy         scan in progress
//   done         1-cycle pulse at scan completion
//   spr_count    sprites found on the line, saturates at MAX_SPR
//   overflow     more than MAX_SPR sprites cover the line

module sprite_line_eval
  import ppu_sprite_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int SPR_H      = 16,
  parameter int MAX_SPR    = 8,
  parameter int LINE_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          line_start,
  input  logic [LINE_W-1:0]             line_num,
  output logic [ADDR_WIDTH-1:0]         ram_rdaddr,
  input  logic [31:0]                   ram_rdata,
  output logic                          out_we,
  output logic [$clog2(MAX_SPR)-1:0]    out_idx,
  output logic [31:0]                   out_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(MAX_SPR):0]      spr_count,
  output logic                          overflow
);

  localparam int                    IDX_W     = $clog2(MAX_SPR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [1:0]        state;
  logic [LINE_W-1:0] line_reg;
  logic              rd_vld;   // ram_rdata holds a sprite word of the current scan
  logic              hit;
  logic [6:0]        row;

  sprite_hit_cmp #(
    .LINE_W (LINE_W),
    .SPR_H  (SPR_H)
  ) u_hit_cmp (
    .y        (spr_field(ram_rdata, Y_LSB)),
    .line_num (line_reg),
    .attr     (spr_field(ram_rdata, ATTR_LSB)),
    .hit      (hit),
    .row      (row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      line_reg   <= '0;
      rd_vld     <= 1'b0;
      ram_rdaddr <= '0;
      out_we     <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spr_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      out_we <= 1'b0;
      done   <= 1'b0;

      if (line_start) begin
        // Accept or restart; any word already in flight belongs to the old line
        // and is dropped by clearing rd_vld without a compare.
        state      <= ST_SCAN;
        ram_rdaddr <= '0;
        line_reg   <= line_num;
        rd_vld     <= 1'b0;
        spr_count  <= '0;
        overflow   <= 1'b0;
        busy       <= (state != ST_IDLE);
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_SCAN: begin
            busy   <= 1'b1;
            rd_vld <= 1'b1;
            if (ram_rdaddr == LAST_ADDR) begin
              state <= ST_DRAIN;
            end else begin
              ram_rdaddr <= ram_rdaddr + 1'b1;
            end
          end
          ST_DRAIN: begin
            rd_vld <= 1'b0;
            if (!rd_vld) begin
              // last compare retired on the previous edge
              state <= ST_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              busy <= 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            rd_vld <= 1'b0;
            busy   <= 1'b0;
          end
        endcase

        if (rd_vld && hit) begin
          // MAX_SPR is a power of two, so the count's MSB alone marks "full".
          if (!spr_count[IDX_W]) begin
            out_we    <= 1'b1;
            out_idx   <= spr_count[IDX_W-1:0];
            out_data  <= {spr_field(ram_rdata, X_LSB),
                          spr_field(ram_rdata, TILE_LSB),
                          spr_field(ram_rdata, ATTR_LSB),
                          1'b0, row};
            spr_count <= spr_count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule
